ddr_port1_reader: RTL and testbench

- Read-side master for the Spartan-6 MCB user port 1; the write-side port-0 controller fills the frame buffer, and this block reads it back.
- Issues sequential read bursts covering one frame region starting at a latched base address, then restarts.
- Drains the port-1 read FIFO into a registered valid/ready pixel stream for the display pipeline.
- Marks the first word of every frame with a start-of-frame flag.

---
 rtl/ddr_pkg.sv | 19 +
 rtl/ddr_port1_reader_if.sv | 34 +++
 rtl/ddr_rd_out_reg.sv | 43 ++++
 rtl/ddr_port1_reader.sv | 144 ++++++++++++++
 tb/tb_ddr_port1_reader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the MCB port-1 frame reader.
// Contents: reader FSM state type, MCB instruction codes, MCB burst and
// word-size limits.
package ddr_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_CAL,
    ST_ARM,
    ST_CMD,
    ST_DRAIN
  } rd_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int MCB_MAX_BL     = 64;
  localparam int MCB_WORD_BYTES = 4;

endpackage

// File: rtl/ddr_port1_reader_if.sv
// MCB user port 1 (command + read FIFO) and the outgoing pixel stream.
// Modports:
//   master - the frame reader: drives the command channel, read pops and
//            the pixel stream.
//   slave  - the MCB side and the display consumer.
interface ddr_port1_reader_if #(
  parameter int ADDR_W = 30
);
  logic              p1_cmd_full;
  logic              p1_cmd_en;
  logic [2:0]        p1_cmd_instr;
  logic [5:0]        p1_cmd_bl;
  logic [ADDR_W-1:0] p1_cmd_byte_addr;
  logic              p1_rd_empty;
  logic [31:0]       p1_rd_data;
  logic              p1_rd_overflow;
  logic              p1_rd_en;
  logic [31:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;

  modport master (
    input  p1_cmd_full, p1_rd_empty, p1_rd_data, p1_rd_overflow, pix_ready,
    output p1_cmd_en, p1_cmd_instr, p1_cmd_bl, p1_cmd_byte_addr, p1_rd_en,
           pix_data, pix_valid, pix_sof
  );

  modport slave (
    output p1_cmd_full, p1_rd_empty, p1_rd_data, p1_rd_overflow, pix_ready,
    input  p1_cmd_en, p1_cmd_instr, p1_cmd_bl, p1_cmd_byte_addr, p1_rd_en,
           pix_data, pix_valid, pix_sof
  );
endinterface

// File: rtl/ddr_rd_out_reg.sv
// Pixel output register and read-FIFO pop control.
// Ports:
//   clk, rst            - clock, async active-high reset
//   drain               - reader is in its drain state (pops allowed)
//   rd_empty, rd_data   - first-word-fall-through read FIFO head
//   sof_in              - next popped word starts a frame
//   pix_ready           - downstream accept
//   pop                 - read FIFO pop strobe (combinational)
//   pix_data/valid/sof  - registered output stream
module ddr_rd_out_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        drain,
  input  logic        rd_empty,
  input  logic [31:0] rd_data,
  input  logic        sof_in,
  input  logic        pix_ready,
  output logic        pop,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof
);

  // Pop when the register is free or is being emptied this cycle, so an
  // accept and a pop in the same cycle sustain one word per clock.
  assign pop = drain && !rd_empty && (!pix_valid || pix_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
    end else if (pop) begin
      pix_data  <= rd_data;
      pix_valid <= 1'b1;
      pix_sof   <= sof_in;
    end else if (pix_valid && pix_ready) begin
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_port1_reader.sv
// Read-side master for MCB user port 1: reads one frame region back from
// DDR in sequential bursts and streams it out with a start-of-frame flag.
// Ports:
//   clk, rst        - clock (shared with MCB port 1), async active-high reset
//   mem_calib_done  - MCB calibration done (asynchronous, synchronised here)
//   enable          - permit a new frame; sampled in ARM only
//   frame_base      - frame byte base address, latched in ARM
//   busy            - high while issuing or draining a burst
//   rd_err_count    - saturating FIFO error count (DDR_RD_ERR_CNT_EN only)
//   bus             - MCB port-1 command/read channel and pixel stream
// Optional feature macro: DDR_RD_ERR_CNT_EN.
//
// state    | meaning
// WAIT_CAL | waiting for synchronised MCB calibration
// ARM      | idle between frames; latch base on enable
// CMD      | issue next read burst when the command FIFO has room
// DRAIN    | pop the burst's words into the output register
module ddr_port1_reader
  import ddr_pkg::*;
#(
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 70560,
  parameter int ADDR_W      = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_calib_done,
  input  logic              enable,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              busy,
`ifdef DDR_RD_ERR_CNT_EN
  output logic [7:0]        rd_err_count,
`endif
  ddr_port1_reader_if.master bus
);

  localparam int BL_EFF = (BURST_LEN > MCB_MAX_BL) ? MCB_MAX_BL : BURST_LEN;
  localparam int WL_W   = $clog2(FRAME_WORDS + 1);

  rd_state_e         state;
  logic              cal_meta, cal_sync;
  logic [ADDR_W-1:0] addr;
  logic [WL_W-1:0]   words_left;
  logic [6:0]        burst_left;
  logic [6:0]        blen;
  logic              sof_pending;
  logic              pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cal_meta <= 1'b0;
      cal_sync <= 1'b0;
    end else begin
      cal_meta <= mem_calib_done;
      cal_sync <= cal_meta;
    end
  end

  // Last burst of a frame shrinks to whatever is left.
  always_comb begin
    blen = 7'(BL_EFF);
    if (32'(words_left) < 32'(BL_EFF)) blen = 7'(words_left);
  end

  assign bus.p1_cmd_instr = CMD_RD;
  assign busy = (state == ST_CMD) || (state == ST_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_WAIT_CAL;
      addr                 <= '0;
      words_left           <= '0;
      burst_left           <= '0;
      sof_pending          <= 1'b0;
      bus.p1_cmd_en        <= 1'b0;
      bus.p1_cmd_bl        <= '0;
      bus.p1_cmd_byte_addr <= '0;
    end else begin
      bus.p1_cmd_en <= 1'b0;
      case (state)
        ST_WAIT_CAL: if (cal_sync) state <= ST_ARM;
        ST_ARM: begin
          if (enable) begin
            addr        <= frame_base;
            words_left  <= WL_W'(FRAME_WORDS);
            sof_pending <= 1'b1;
            state       <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!bus.p1_cmd_full) begin
            bus.p1_cmd_en        <= 1'b1;
            bus.p1_cmd_bl        <= 6'(blen - 7'd1);
            bus.p1_cmd_byte_addr <= addr;
            addr                 <= addr + ADDR_W'(blen) * ADDR_W'(MCB_WORD_BYTES);
            words_left           <= words_left - WL_W'(blen);
            burst_left           <= blen;
            state                <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop) begin
            sof_pending <= 1'b0;
            burst_left  <= burst_left - 7'd1;
            if (burst_left == 7'd1) state <= (words_left == '0) ? ST_ARM : ST_CMD;
          end
        end
        default: state <= ST_WAIT_CAL;
      endcase
    end
  end

  ddr_rd_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .drain     (state == ST_DRAIN),
    .rd_empty  (bus.p1_rd_empty),
    .rd_data   (bus.p1_rd_data),
    .sof_in    (sof_pending),
    .pix_ready (bus.pix_ready),
    .pop       (pop),
    .pix_data  (bus.pix_data),
    .pix_valid (bus.pix_valid),
    .pix_sof   (bus.pix_sof)
  );

  assign bus.p1_rd_en = pop;

`ifdef DDR_RD_ERR_CNT_EN
  // Popping an empty FIFO should never happen; counted as a backstop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err_count <= '0;
    end else if ((bus.p1_rd_overflow || (pop && bus.p1_rd_empty)) &&
                 (rd_err_count != 8'hFF)) begin
      rd_err_count <= rd_err_count + 8'd1;
    end
  end
`else
  logic unused_overflow;
  assign unused_overflow = bus.p1_rd_overflow;
`endif

endmodule

// File: tb/tb_ddr_port1_reader.sv
// Directed bench for ddr_port1_reader with a small MCB read-port model.
module tb_ddr_port1_reader;
  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_calib_done;
  logic              enable;
  logic [ADDR_W-1:0] frame_base;
  logic              busy;
`ifdef DDR_RD_ERR_CNT_EN
  logic [7:0]        rd_err_count;
`endif

  ddr_port1_reader_if #(.ADDR_W(ADDR_W)) bus ();

  ddr_port1_reader #(.BURST_LEN(64), .FRAME_WORDS(200), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_calib_done (mem_calib_done),
    .enable         (enable),
    .frame_base     (frame_base),
    .busy           (busy),
`ifdef DDR_RD_ERR_CNT_EN
    .rd_err_count   (rd_err_count),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // MCB model: a command immediately lands bl+1 words in the read FIFO.
  logic [31:0] fifo[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo.delete();
    end else begin
      if (bus.p1_rd_en && fifo.size() > 0) void'(fifo.pop_front());
      if (bus.p1_cmd_en)
        for (int i = 0; i <= int'(bus.p1_cmd_bl); i++)
          fifo.push_back(wd(32'(bus.p1_cmd_byte_addr) + 32'(4 * i)));
    end
    bus.p1_rd_empty <= (fifo.size() == 0);
    bus.p1_rd_data  <= (fifo.size() > 0) ? fifo[0] : 32'h0;
  end

  // Monitor: accepted words, issued commands, stall and pop-rule tracking.
  logic [32:0] words[$];
  logic [31:0] cmd_addr[$];
  logic [5:0]  cmd_bl[$];
  int          stall_err = 0;
  int          rden_err  = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_sof;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && !(bus.pix_valid && bus.pix_data == prev_data && bus.pix_sof == prev_sof))
        stall_err++;
      if (bus.p1_rd_en && bus.pix_valid && !bus.pix_ready) rden_err++;
      if (bus.pix_valid && bus.pix_ready) words.push_back({bus.pix_sof, bus.pix_data});
      if (bus.p1_cmd_en) begin
        cmd_addr.push_back(32'(bus.p1_cmd_byte_addr));
        cmd_bl.push_back(bus.p1_cmd_bl);
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_data  = bus.pix_data;
      prev_sof   = bus.pix_sof;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    words.delete();
    cmd_addr.delete();
    cmd_bl.delete();
  endtask

  task automatic wait_words(input int n, input int budget, input bit bp);
    int c = 0;
    while (words.size() < n && c < budget) begin
      @(posedge clk); #1;
      if (bp) bus.pix_ready = ($urandom_range(0, 99) >= 30);
      c++;
    end
    bus.pix_ready = 1'b1;
    chk("wait_words", 64'(words.size() >= n), 64'd1);
  endtask

  task automatic wait_cmd(input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (bus.p1_cmd_en) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int start, input logic [31:0] base, input int n);
    int errs = 0;
    for (int k = 0; k < n; k++)
      if (start + k >= words.size() ||
          words[start + k] !== {(k == 0), wd(base + 32'(4 * k))}) errs++;
    chk(tag, 64'(errs), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_en"}, 64'(bus.p1_cmd_en), 64'd0);
    chk({tag, "_instr"}, 64'(bus.p1_cmd_instr), 64'd1);
    chk({tag, "_bl"}, 64'(bus.p1_cmd_bl), 64'd0);
    chk({tag, "_addr"}, 64'(bus.p1_cmd_byte_addr), 64'd0);
    chk({tag, "_rd_en"}, 64'(bus.p1_rd_en), 64'd0);
    chk({tag, "_valid"}, 64'(bus.pix_valid), 64'd0);
    chk({tag, "_data"}, 64'(bus.pix_data), 64'd0);
    chk({tag, "_sof"}, 64'(bus.pix_sof), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    mem_calib_done = 1'b0;
    enable = 1'b0;
    frame_base = 30'h1000;
    bus.p1_cmd_full = 1'b0;
    bus.p1_rd_overflow = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Calibration gate.
    enable = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("cal_gate_no_cmd", 64'(cmd_addr.size()), 64'd0);
    chk("cal_gate_busy", 64'(busy), 64'd0);
    mem_calib_done = 1'b1;
    // 2-flop sync, WAIT_CAL->ARM, ARM->CMD, registered strobe.
    wait_cmd(8, lat);
    enable = 1'b0;
    chk("cal_first_cmd_seen", 64'(lat > 0 && lat <= 6), 64'd1);
    chk("cal_first_bl", 64'(bus.p1_cmd_bl), 64'd63);
    chk("cal_first_addr", 64'(bus.p1_cmd_byte_addr), 64'h1000);

    // Full frame at 0x1000: 3x64 + 8 words.
    wait_words(200, 1000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("frame_cmd_count", 64'(cmd_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < cmd_addr.size(); i++) begin
      chk("frame_cmd_addr", 64'(cmd_addr[i]), 64'(32'h1000 + 32'(i) * 32'h100));
      chk("frame_cmd_bl", 64'(cmd_bl[i]), (i == 3) ? 64'd7 : 64'd63);
    end
    chk("frame_word_count", 64'(words.size()), 64'd200);
    check_frame("frame_data", 0, 32'h1000, 200);
    chk("frame_idle_busy", 64'(busy), 64'd0);

    // Random backpressure at 30%.
    clear_logs();
    frame_base = 30'h2000;
    enable = 1'b1;
    wait_cmd(10, lat);
    enable = 1'b0;
    chk("bp_cmd_seen", 64'(lat > 0), 64'd1);
    wait_words(200, 3000, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_word_count", 64'(words.size()), 64'd200);
    check_frame("bp_data", 0, 32'h2000, 200);
    chk("bp_stall_stable", 64'(stall_err), 64'd0);
    chk("bp_no_pop_on_stall", 64'(rden_err), 64'd0);

    // Command FIFO full while in CMD.
    clear_logs();
    frame_base = 30'h3000;
    bus.p1_cmd_full = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) begin
      @(posedge clk); #1;
    end
    enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("full_no_cmd", 64'(cmd_addr.size()), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    bus.p1_cmd_full = 1'b0;
    @(posedge clk); #1;
    chk("full_release_cmd_en", 64'(bus.p1_cmd_en), 64'd1);
    chk("full_release_addr", 64'(bus.p1_cmd_byte_addr), 64'h3000);
    wait_words(200, 1000, 1'b0);
    check_frame("full_data", 0, 32'h3000, 200);

    // Frame restart with base changed mid-frame.
    repeat (5) @(posedge clk);
    #1;
    clear_logs();
    frame_base = 30'h4000;
    enable = 1'b1;
    wait_words(100, 1000, 1'b0);
    frame_base = 30'h11340;
    wait_words(201, 1000, 1'b0);
    check_frame("restart_old_frame", 0, 32'h4000, 200);
    chk("restart_new_first_word", 64'(words.size() > 200 ? words[200] : 33'h0),
        64'({1'b1, wd(32'h11340)}));
    chk("restart_cmd5_addr", 64'(cmd_addr.size() > 4 ? cmd_addr[4] : 32'h0), 64'h11340);

    // Reset 10 words into the new frame's first burst.
    wait_words(210, 200, 1'b0);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    frame_base = 30'h5000;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_wait_cal_busy", 64'(busy), 64'd0);
    chk("post_rst_wait_cal_no_cmd", 64'(cmd_addr.size()), 64'd0);
    wait_words(1, 200, 1'b0);
    enable = 1'b0;
    chk("post_rst_first_word", 64'(words.size() > 0 ? words[0] : 33'h0),
        64'({1'b1, wd(32'h5000)}));
    chk("post_rst_first_addr", 64'(cmd_addr.size() > 0 ? cmd_addr[0] : 32'h0), 64'h5000);
    chk("post_rst_first_bl", 64'(cmd_bl.size() > 0 ? cmd_bl[0] : 6'h0), 64'd63);
`ifdef DDR_RD_ERR_CNT_EN
    chk("err_count", 64'(rd_err_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
